// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Unified instruction/data memory sequencer: round-robin arbitration between the
// CPU datapath (id 0) and the loader/debug port (id 1), fixed-latency access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_err,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] { IDLE, BUSY, DONE } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel       = (cpu_req && ld_req) ? ~last_q : ld_req;
    sel_we    = sel ? ld_we    : cpu_we;
    sel_addr  = sel ? ld_addr  : cpu_addr;
    sel_wdata = sel ? ld_wdata : cpu_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          gnt_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_addr[1:0] != 2'b00) begin
            // rdata is cleared on the way into DONE so it reads 0 with the ack
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The counter holds its load value only in the first BUSY cycle.
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) && we_q && (cnt_q == CNT_LOAD);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  assign cpu_ack   = (state_q == DONE) && !gnt_q;
  assign ld_ack    = (state_q == DONE) &&  gnt_q;
  assign cpu_err   = cpu_ack && err_q;
  assign ld_err    = ld_ack  && err_q;
  assign cpu_rdata = rdata_q;
  assign ld_rdata  = rdata_q;
  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: three instances (latency 1, 4, 3) sharing one clock,
// each with a behavioural memory that presents valid data only in the last BUSY cycle.
module tb_mem_port_arbiter;

  localparam int NI = 3;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        cpu_req   [NI];
  logic        cpu_we    [NI];
  logic [31:0] cpu_addr  [NI];
  logic [31:0] cpu_wdata [NI];
  logic        cpu_ack   [NI];
  logic        cpu_err   [NI];
  logic [31:0] cpu_rdata [NI];
  logic        cpu_stall [NI];
  logic        ld_req    [NI];
  logic        ld_we     [NI];
  logic [31:0] ld_addr   [NI];
  logic [31:0] ld_wdata  [NI];
  logic        ld_ack    [NI];
  logic        ld_err    [NI];
  logic [31:0] ld_rdata  [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        busy      [NI];

  logic [31:0] mem  [NI][64];
  int          bcnt [NI];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MEM_LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 3))
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_err(cpu_err[g]), .cpu_rdata(cpu_rdata[g]), .cpu_stall(cpu_stall[g]),
      .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_wdata(ld_wdata[g]),
      .ld_ack(ld_ack[g]), .ld_err(ld_err[g]), .ld_rdata(ld_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
  endfunction

  // Memory: valid data only in the MEM_LATENCY-th consecutive mem_en cycle, junk otherwise.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_en[k] === 1'b1) begin
        bcnt[k] = bcnt[k] + 1;
        if (mem_we[k] === 1'b1) mem[k][mem_addr[k][7:2]] = mem_wdata[k];
        mem_rdata[k] = (bcnt[k] == lat(k)) ? mem[k][mem_addr[k][7:2]] : (32'hBAD0_0000 | 32'(cyc));
      end else begin
        bcnt[k] = 0;
        mem_rdata[k] = 32'hBAD0_0000 | 32'(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({busy[k], cpu_ack[k], ld_ack[k], mem_en[k], mem_we[k], cpu_err[k], ld_err[k]} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b required 0000000", k,
                 {busy[k], cpu_ack[k], ld_ack[k], mem_en[k], mem_we[k], cpu_err[k], ld_err[k]});
      end
      n_checks++;
      if (mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mem_regs[%0d]: got addr %h wdata %h required 0", k, mem_addr[k], mem_wdata[k]);
      end
      n_checks++;
      if (cpu_rdata[k] !== 32'h0 || ld_rdata[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rdata[%0d]: got %h/%h required 0", k, cpu_rdata[k], ld_rdata[k]);
      end
    end
    tick();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
  endtask

  task automatic test_cpu_read();
    int t;
    bit got = 0;
    exp_t e;
    cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10; cpu_req[0] = 1'b1;
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF, t + 2});
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      n_checks++;
      if (mem_en[0] !== (cyc == t + 1)) begin
        n_fail++; $display("FAIL cpu_read_mem_en@%0d: got %b required %b", cyc - t, mem_en[0], cyc == t + 1);
      end
      n_checks++;
      if (ld_ack[0] !== 1'b0) begin
        n_fail++; $display("FAIL cpu_read_ld_ack@%0d: got %b required 0", cyc - t, ld_ack[0]);
      end
      if (cyc <= t + 1) begin
        n_checks++;
        if (cpu_stall[0] !== 1'b1) begin
          n_fail++; $display("FAIL cpu_read_stall@%0d: got %b required 1", cyc - t, cpu_stall[0]);
        end
      end
      if (cpu_ack[0] === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cyc || cpu_rdata[0] !== e.rdata || cpu_err[0] !== e.err || cpu_stall[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL cpu_read_ack: got cyc %0d data %h err %b stall %b required cyc %0d data %h err %b stall 0",
                   cyc, cpu_rdata[0], cpu_err[0], cpu_stall[0], e.cyc, e.rdata, e.err);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL cpu_read_timeout: got no ack required ack"); sb.delete(); end
    tick();
    cpu_req[0] = 1'b0;
  endtask

  task automatic test_ld_write();
    int t;
    int wecnt = 0;
    bit got = 0;
    exp_t e;
    ld_we[0] = 1'b1; ld_addr[0] = 32'h20; ld_wdata[0] = 32'h1234_5678; ld_req[0] = 1'b1;
    t = cyc;
    sb.push_back('{1'b1, 1'b0, 32'h0, t + 2});
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (mem_we[0] === 1'b1) wecnt++;
      if (cyc == t + 1) begin
        n_checks++;
        if (mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h20 || mem_wdata[0] !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL ld_write_strobe: got we %b addr %h data %h required 1 00000020 12345678",
                   mem_we[0], mem_addr[0], mem_wdata[0]);
        end
      end
      n_checks++;
      if (cpu_ack[0] !== 1'b0 || cpu_stall[0] !== 1'b0 || cpu_err[0] !== 1'b0) begin
        n_fail++; $display("FAIL ld_write_cpu_idle: got ack %b stall %b err %b required 0", cpu_ack[0], cpu_stall[0], cpu_err[0]);
      end
      if (ld_ack[0] === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cyc || ld_err[0] !== e.err) begin
          n_fail++; $display("FAIL ld_write_ack: got cyc %0d err %b required cyc %0d err 0", cyc, ld_err[0], e.cyc);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL ld_write_timeout: got no ack required ack"); sb.delete(); end
    tick();
    ld_req[0] = 1'b0;
    n_checks++;
    if (wecnt != 1 || mem[0][8] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL ld_write_commit: got %0d strobes word %h required 1 strobe 12345678", wecnt, mem[0][8]);
    end
  endtask

  task automatic test_fairness();
    int t;
    int acks = 0;
    exp_t e;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10; cpu_req[0] = 1'b1;
    ld_we[0]  = 1'b0; ld_addr[0]  = 32'h24; ld_req[0]  = 1'b1;
    t = cyc;
    for (int i = 0; i < 6; i++)
      sb.push_back('{1'(i % 2), 1'b0, (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hA5A5_0001, t + 2 + 3 * i});
    for (int n = 0; n < 40 && acks < 6; n++) begin
      @(negedge clk);
      if (cpu_ack[0] === 1'b1 || ld_ack[0] === 1'b1) begin
        acks++;
        n_checks++;
        if (sb.size() == 0 || (cpu_ack[0] === 1'b1 && ld_ack[0] === 1'b1)) begin
          n_fail++; $display("FAIL fair_unexpected_ack: got cpu %b ld %b required single expected ack", cpu_ack[0], ld_ack[0]);
        end else begin
          e = sb.pop_front();
          if (ld_ack[0] !== e.id || cyc !== e.cyc || cpu_rdata[0] !== e.rdata) begin
            n_fail++;
            $display("FAIL fair_grant%0d: got id %b cyc %0d data %h required id %b cyc %0d data %h",
                     acks, ld_ack[0], cyc, cpu_rdata[0], e.id, e.cyc, e.rdata);
          end
        end
      end
    end
    n_checks++;
    if (acks < 6) begin n_fail++; $display("FAIL fair_timeout: got %0d acks required 6", acks); sb.delete(); end
    tick();
    cpu_req[0] = 1'b0; ld_req[0] = 1'b0;
  endtask

  task automatic test_misaligned();
    int t;
    bit got = 0;
    cpu_we[0] = 1'b0; cpu_addr[0] = 32'h6; cpu_req[0] = 1'b1;
    t = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h0, t + 1});
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_checks++;
      if (mem_en[0] !== 1'b0 || mem_we[0] !== 1'b0 || ld_ack[0] !== 1'b0) begin
        n_fail++; $display("FAIL misaligned_no_access@%0d: got en %b we %b ld_ack %b required 0", cyc - t, mem_en[0], mem_we[0], ld_ack[0]);
      end
      if (cpu_ack[0] === 1'b1) begin
        exp_t e;
        cpu_req[0] = 1'b0;
        n_checks++;
        if (got || sb.size() == 0) begin
          n_fail++; $display("FAIL misaligned_extra_ack: got ack at %0d required single ack", cyc - t);
        end else begin
          got = 1;
          e = sb.pop_front();
          if (cyc !== e.cyc || cpu_err[0] !== e.err || cpu_rdata[0] !== e.rdata) begin
            n_fail++;
            $display("FAIL misaligned_ack: got cyc %0d err %b data %h required cyc %0d err 1 data 00000000",
                     cyc, cpu_err[0], cpu_rdata[0], e.cyc);
          end
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL misaligned_timeout: got no ack required ack"); sb.delete(); end
    cpu_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_latency4();
    int t;
    bit got = 0;
    exp_t e;
    cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40; cpu_req[1] = 1'b1;
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'hCAFE_F00D, t + 5});
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      n_checks++;
      if (mem_en[1] !== (cyc >= t + 1 && cyc <= t + 4)) begin
        n_fail++; $display("FAIL lat4_mem_en@%0d: got %b required %b", cyc - t, mem_en[1], cyc >= t + 1 && cyc <= t + 4);
      end
      if (cyc == t + 1) begin
        n_checks++;
        if (mem_addr[1] !== 32'h40 || mem_we[1] !== 1'b0) begin
          n_fail++; $display("FAIL lat4_addr: got %h we %b required 00000040 we 0", mem_addr[1], mem_we[1]);
        end
      end
      if (cpu_ack[1] === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cyc || cpu_rdata[1] !== e.rdata || cpu_err[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL lat4_ack: got cyc %0d data %h err %b required cyc %0d data %h err 0", cyc, cpu_rdata[1], cpu_err[1], e.cyc, e.rdata);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL lat4_timeout: got no ack required ack"); sb.delete(); end
    tick();
    cpu_req[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    int acks = 0;
    exp_t e;
    // A completed CPU access leaves last_grant at the CPU, so only reset can make the CPU win the next tie.
    cpu_we[2] = 1'b0; cpu_addr[2] = 32'h8; cpu_req[2] = 1'b1;
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'h1111_2222, t + 4});
    for (int n = 0; n < 10 && acks < 1; n++) begin
      @(negedge clk);
      if (cpu_ack[2] === 1'b1) begin
        acks++;
        cpu_req[2] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cyc || cpu_rdata[2] !== e.rdata) begin
          n_fail++; $display("FAIL lat3_ack: got cyc %0d data %h required cyc %0d data %h", cyc, cpu_rdata[2], e.cyc, e.rdata);
        end
      end
    end
    n_checks++;
    if (acks < 1) begin n_fail++; $display("FAIL lat3_timeout: got no ack required ack"); sb.delete(); end
    cpu_req[2] = 1'b0;
    tick();

    cpu_addr[2] = 32'h14; cpu_req[2] = 1'b1;
    t = cyc;
    tick();
    tick();
    rst[2] = 1'b1; cpu_req[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_en[2] !== 1'b1 || busy[2] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_busy@%0d: got en %b busy %b required 1 1", cyc - t, mem_en[2], busy[2]);
    end
    tick();
    rst[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if (busy[2] !== 1'b0 || cpu_ack[2] !== 1'b0 || ld_ack[2] !== 1'b0 || mem_en[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_abandon@%0d: got busy %b cpu_ack %b ld_ack %b en %b required 0",
                 cyc - t, busy[2], cpu_ack[2], ld_ack[2], mem_en[2]);
      end
    end

    tick();
    cpu_addr[2] = 32'h8;  cpu_req[2] = 1'b1;
    ld_we[2] = 1'b0; ld_addr[2] = 32'h14; ld_req[2] = 1'b1;
    t = cyc;
    sb.push_back('{1'b0, 1'b0, 32'h1111_2222, t + 4});
    sb.push_back('{1'b1, 1'b0, 32'h3333_4444, t + 9});
    acks = 0;
    for (int n = 0; n < 20 && acks < 2; n++) begin
      @(negedge clk);
      if (cpu_ack[2] === 1'b1 || ld_ack[2] === 1'b1) begin
        acks++;
        if (cpu_ack[2] === 1'b1) cpu_req[2] = 1'b0;
        if (ld_ack[2] === 1'b1) ld_req[2] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (ld_ack[2] !== e.id || cyc !== e.cyc || ld_rdata[2] !== e.rdata) begin
          n_fail++;
          $display("FAIL rstmid_grant%0d: got id %b cyc %0d data %h required id %b cyc %0d data %h",
                   acks, ld_ack[2], cyc, ld_rdata[2], e.id, e.cyc, e.rdata);
        end
      end
    end
    n_checks++;
    if (acks < 2) begin n_fail++; $display("FAIL rstmid_timeout: got %0d acks required 2", acks); sb.delete(); end
    cpu_req[2] = 1'b0; ld_req[2] = 1'b0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      ld_req[k]  = 1'b0; ld_we[k]  = 1'b0; ld_addr[k]  = '0; ld_wdata[k]  = '0;
      for (int w = 0; w < 64; w++) mem[k][w] = 32'h5500_0000 | 32'(w);
    end
    mem[0][4]  = 32'hDEAD_BEEF;
    mem[0][9]  = 32'hA5A5_0001;
    mem[1][16] = 32'hCAFE_F00D;
    mem[2][2]  = 32'h1111_2222;
    mem[2][5]  = 32'h3333_4444;

    test_reset();
    test_cpu_read();
    test_ld_write();
    test_fairness();
    test_misaligned();
    test_latency4();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single unified instruction/data memory of the multicycle CPU and shares it between two requesters.
- Requester 0 is the CPU datapath (fetch and load/store); requester 1 is the program loader/debug port.
- Round-robin arbitration, fixed-latency memory sequencing, misalignment check, and a stall output that holds the CPU control FSM until its access completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (legal range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  CPU write enable (1 = store)
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU store data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_err  out  1  misaligned-access flag, valid with cpu_ack
cpu_rdata  out  DATA_W  read data, valid with cpu_ack
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
ld_req  in  1  loader request, held until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  ADDR_W  loader byte address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle completion pulse to loader
ld_err  out  1  misaligned flag, valid with ld_ack
ld_rdata  out  DATA_W  read data, valid with ld_ack
mem_en  out  1  memory access enable
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en first high
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - State IDLE; all acks, errs, mem_en, mem_we and busy low.
  - rdata register, mem_addr and mem_wdata zero; last_grant = 1, so the CPU wins the first tie.
- Reset mid-operation: the in-flight access is abandoned with no ack. A write whose mem_we already pulsed stays committed.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until the cycle its ack is high.
  - req still high in the cycle after ack is a new request.
  - Ack is exactly one cycle wide.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the requester != last_grant.
  - On grant, latch we/addr/wdata into the mem_* registers and record the granted id.
  - addr[1:0] != 0: go to DONE with err = 1, no memory access.
  - Otherwise go to BUSY and load the counter with MEM_LATENCY - 1.
- BUSY:
  - mem_en high for every BUSY cycle.
  - mem_we high only in the first BUSY cycle and only for writes.
  - Counter decrements each cycle. At counter == 0, capture mem_rdata (reads only; writes leave the register unchanged) and go to DONE.
- DONE:
  - Ack (and err if set) asserted to the granted requester only.
  - last_grant takes the granted id; return to IDLE.
  - The rdata register clears to 0 on an err access.
- Latency: req first high in IDLE at cycle t gives BUSY during t+1..t+MEM_LATENCY and ack at t+MEM_LATENCY+1. A misaligned access acks at t+1.
- Sustained throughput: one access per MEM_LATENCY+2 cycles.
- rdata outputs: both drive the shared rdata register. Contents are defined only in the owning ack cycle and hold otherwise.
- A req arriving while not IDLE waits; it is sampled at the next IDLE cycle.
- Fairness: with both requesters continuously requesting, grants strictly alternate.

Test Plan:
1. Reset, then cpu_req read addr 0x0000_0010, mem returns 0xDEAD_BEEF (MEM_LATENCY=1) -> mem_en high at t+1; cpu_ack=1 with cpu_rdata=0xDEAD_BEEF at t+2; cpu_stall high at t and t+1; ld_ack stays 0.
2. ld_req write addr 0x20, data 0x1234_5678 -> mem_we high exactly one cycle at t+1 with mem_addr=0x20; ld_ack at t+2; cpu outputs idle.
3. cpu_req and ld_req both held high from reset for 6 accesses -> grant order CPU, LD, CPU, LD, CPU, LD; one ack every 3 cycles.
4. cpu_req read addr 0x0000_0006 -> cpu_ack and cpu_err at t+1, cpu_rdata=0, mem_en never asserted.
5. MEM_LATENCY=4, read addr 0x40 -> mem_en high t+1..t+4, ack at t+5, data sampled at the t+4 edge.
6. reset asserted during second BUSY cycle of an MEM_LATENCY=3 read -> next cycle IDLE, no ack, busy=0; a following CPU request wins over a pending loader request (last_grant reset to 1).
